display_frame_scheduler: RTL

Triple-buffer frame scheduler that sits between the camera write path, the frame-buffer DMA read channel and the LVDS display timing generator, all in the `lvds_slowclk` domain. It assigns frame buffers to the writer and the reader without tearing. On each display vsync falling edge it picks the newest completed frame, or repeats the current one, and issues one DMA read command for a whole frame. It also reports frame-level statistics and late-DMA errors to the debug registers.

---
 rtl/display_frame_scheduler.sv | 100 ++++++++++
 1 files changed

// File: rtl/display_frame_scheduler.sv
// display_frame_scheduler: triple-buffer frame scheduler issuing one whole-frame DMA read per display vsync.
module display_frame_scheduler #(
  parameter logic [31:0] BASE_ADDR   = 32'h0100_0000,
  parameter logic [31:0] BUF_STRIDE  = 32'h0020_0000,
  parameter logic [31:0] FRAME_BYTES = 32'd1228800
) (
  input  logic        lvds_slowclk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        display_vsync,
  input  logic        wr_frame_done,
  output logic [1:0]  wr_buf_idx,
  output logic [1:0]  rd_buf_idx,
  output logic        dma_cmd_valid,
  input  logic        dma_cmd_ready,
  output logic [31:0] dma_cmd_addr,
  output logic [31:0] dma_cmd_len,
  input  logic        dma_done,
  output logic [31:0] frames_shown,
  output logic [31:0] frames_repeated,
  output logic [31:0] late_count,
  output logic        dma_late
);
  typedef enum logic [1:0] {IDLE, WAIT_VS, ISSUE, BUSY} state_t;
  state_t state, state_nxt;
  logic vs_q, vs_fall, dispatch, late, rd_swap;
  logic [1:0] lat, next_rd;
  logic fresh, latest_valid;
  assign vs_fall = vs_q & ~display_vsync;
  assign rd_swap = dispatch & fresh;
  assign next_rd = rd_swap ? lat : rd_buf_idx;
  assign dma_cmd_valid = (state == ISSUE);
  always_comb begin
    state_nxt = state;
    dispatch  = 1'b0;
    late      = 1'b0;
    case (state)
      IDLE:    state_nxt = enable ? WAIT_VS : IDLE;
      WAIT_VS: begin
        dispatch  = enable & vs_fall & latest_valid;
        state_nxt = !enable ? IDLE : dispatch ? ISSUE : WAIT_VS;
      end
      ISSUE: begin
        late      = vs_fall;
        state_nxt = dma_cmd_ready ? BUSY : ISSUE;
      end
      BUSY: begin
        late      = vs_fall;
        state_nxt = !dma_done ? BUSY : enable ? WAIT_VS : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge lvds_slowclk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      vs_q            <= 1'b1;
      rd_buf_idx      <= 2'd0;
      wr_buf_idx      <= 2'd1;
      lat             <= 2'd2;
      fresh           <= 1'b0;
      latest_valid    <= 1'b0;
      dma_cmd_addr    <= '0;
      dma_cmd_len     <= '0;
      frames_shown    <= '0;
      frames_repeated <= '0;
      late_count      <= '0;
      dma_late        <= 1'b0;
    end else begin
      state <= state_nxt;
      vs_q  <= display_vsync;
      // Both swaps in one cycle rotate all three indices using the old values.
      if (wr_frame_done && rd_swap) begin
        rd_buf_idx <= lat;
        lat        <= wr_buf_idx;
        wr_buf_idx <= rd_buf_idx;
        fresh      <= 1'b1;
      end else if (wr_frame_done) begin
        lat        <= wr_buf_idx;
        wr_buf_idx <= lat;
        fresh      <= 1'b1;
      end else if (rd_swap) begin
        rd_buf_idx <= lat;
        lat        <= rd_buf_idx;
        fresh      <= 1'b0;
      end
      if (wr_frame_done) latest_valid <= 1'b1;
      if (dispatch) begin
        dma_cmd_addr <= BASE_ADDR + {30'd0, next_rd} * BUF_STRIDE;
        dma_cmd_len  <= FRAME_BYTES;
      end
      if (dispatch && !fresh) frames_repeated <= frames_repeated + 32'd1;
      if (state == BUSY && dma_done) frames_shown <= frames_shown + 32'd1;
      if (late) begin
        late_count <= late_count + 32'd1;
        dma_late   <= 1'b1;
      end
    end
  end
endmodule
